// File: rtl/galaksija_pkg.sv
// Shared constants and types for the Galaksija keyboard matrix:
// key indices of the special keys, the press FSM states and the decoded-key record.
package galaksija_pkg;

    localparam logic [5:0] KEY_SHIFT = 6'd53;
    localparam logic [5:0] KEY_ENTER = 6'd48;
    localparam logic [5:0] KEY_BREAK = 6'd49;
    localparam logic [5:0] KEY_LEFT  = 6'd29;
    localparam logic [5:0] KEY_SPACE = 6'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       shift;
        logic [5:0] code;
    } keycode_t;

    function automatic keycode_t mk_key(input logic shift, input logic [5:0] code);
        keycode_t k;
        k.valid = 1'b1;
        k.shift = shift;
        k.code  = code;
        return k;
    endfunction

endpackage

// File: rtl/galaksija_keycode.sv
// Combinational ASCII byte to Galaksija matrix key decoder.
// Bytes with no key on the matrix come out with valid=0.
module galaksija_keycode
    import galaksija_pkg::*;
(
    input  logic [7:0] data_i,
    output keycode_t   key_o
);

    always_comb begin
        key_o = '0;
        // Letters share their low five bits between cases: 'A'/'a' -> 1 .. 'Z'/'z' -> 26.
        if ((data_i >= 8'h41 && data_i <= 8'h5A) || (data_i >= 8'h61 && data_i <= 8'h7A)) begin
            key_o = mk_key(1'b0, {1'b0, data_i[4:0]});
        end else if (data_i >= 8'h30 && data_i <= 8'h39) begin
            key_o = mk_key(1'b0, {2'b10, data_i[3:0]});
        end else begin
            case (data_i)
                8'h0A, 8'h0D: key_o = mk_key(1'b0, KEY_ENTER);
                8'h08, 8'h7F: key_o = mk_key(1'b0, KEY_LEFT);
                8'h1B:        key_o = mk_key(1'b0, KEY_BREAK);
                8'h20:        key_o = mk_key(1'b0, KEY_SPACE);
                8'h5F:        key_o = mk_key(1'b1, 6'd32);
                8'h21:        key_o = mk_key(1'b1, 6'd33);
                8'h22:        key_o = mk_key(1'b1, 6'd34);
                8'h23:        key_o = mk_key(1'b1, 6'd35);
                8'h24:        key_o = mk_key(1'b1, 6'd36);
                8'h25:        key_o = mk_key(1'b1, 6'd37);
                8'h26:        key_o = mk_key(1'b1, 6'd38);
                8'h5C:        key_o = mk_key(1'b1, 6'd39);
                8'h28:        key_o = mk_key(1'b1, 6'd40);
                8'h29:        key_o = mk_key(1'b1, 6'd41);
                8'h2B:        key_o = mk_key(1'b1, 6'd42);
                8'h2A:        key_o = mk_key(1'b1, 6'd43);
                8'h3C:        key_o = mk_key(1'b1, 6'd44);
                8'h2D:        key_o = mk_key(1'b1, 6'd45);
                8'h3E:        key_o = mk_key(1'b1, 6'd46);
                8'h3F:        key_o = mk_key(1'b1, 6'd47);
                8'h3B:        key_o = mk_key(1'b0, 6'd42);
                8'h3A:        key_o = mk_key(1'b0, 6'd43);
                8'h2C:        key_o = mk_key(1'b0, 6'd44);
                8'h3D:        key_o = mk_key(1'b0, 6'd45);
                8'h2E:        key_o = mk_key(1'b0, 6'd46);
                8'h2F:        key_o = mk_key(1'b0, 6'd47);
                default:      key_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/serial_keymatrix.sv
// Serial keyboard bytes -> timed presses on the 64-key Galaksija matrix.
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte offered while the queue is full is dropped and flagged on overflow.
module serial_keymatrix
    import galaksija_pkg::*;
#(
    parameter int HOLD_CYCLES = 1500000,
    parameter int GAP_CYCLES  = 500000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd,
    input  logic [5:0] rd_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       overflow,
    output state_t     dbg_state
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             overflow_q, overflow_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      keys_q, keys_d;
    logic [7:0]       key_out_q, key_out_d;
    keycode_t         head_key;

    // Pending-byte queue. A pop in the same cycle frees the slot for a push.
    always_comb begin
        fifo_empty = (fill_q == '0);
        fifo_full  = (fill_q == FILL_FULL);
        push       = rx_valid && (!fifo_full || pop);
        overflow_d = rx_valid && fifo_full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fill_d     = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FILL_ONE;
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    galaksija_keycode u_keycode (
        .data_i (fifo_mem_q[rd_ptr_q]),
        .key_o  (head_key)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && head_key.valid) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (queue pop, counter and key vector). Unmapped bytes are popped without a press.
    always_comb begin
        pop    = 1'b0;
        cnt_d  = cnt_q;
        keys_d = keys_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_key.valid) begin
                        keys_d                = '0;
                        keys_d[head_key.code] = 1'b1;
                        if (head_key.shift) begin
                            keys_d[KEY_SHIFT] = 1'b1;
                        end
                        cnt_d = HOLD_LOAD;
                    end
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    keys_d = '0;
                    cnt_d  = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                keys_d = '0;
                cnt_d  = '0;
            end
        endcase
    end

    // CPU read port samples the key vector before this edge's update.
    always_comb begin
        key_out_d = key_out_q;
        if (rd) begin
            key_out_d = keys_q[rd_addr] ? 8'hFE : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            keys_q    <= '0;
            key_out_q <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            keys_q    <= keys_d;
            key_out_q <= key_out_d;
        end
    end

    assign key_out   = key_out_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
